jt5205_adpcm_mc: RTL

JT5205_ADPCM_MC -- requirements
Module: jt5205_adpcm_mc

---
 rtl/jt5205_adpcm_mc.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/jt5205_adpcm_mc.sv
// Time-multiplexed MSM5205-style ADPCM decoder for CH channels sharing one adder datapath.
// Latency: channel n sample updates 5*(n+1) cen_hf ticks after the cen_lo that latched its nibble.
// No backpressure: nibbles are sampled on every cen_lo, din_ack reports which were taken.
// Optional: define JT5205_DECAY_EN to decay idle channels towards zero instead of holding them.
module jt5205_adpcm_mc #(
    parameter int CH = 4,
    parameter int SW = 12
) (
    input  logic              rst,
    input  logic              clk,
    input  logic              cen_hf,
    input  logic              cen_lo,
    input  logic [4*CH-1:0]   din,
    input  logic [CH-1:0]     din_ok,
    output logic [CH-1:0]     din_ack,
    output logic [SW*CH-1:0]  sound,
    output logic              sample_ok
);

    typedef enum logic [2:0] {IDLE, LOAD, ADD0, ADD1, ADD2, STORE} state_t;

    state_t             state;
    logic [2:0]         ch;
    logic [10:0]        step;
    logic [11:0]        q;

    logic [3:0]         hold_nib [CH];
    logic               hold_ok  [CH];
    logic signed [11:0] acc      [CH];
    logic [5:0]         idx      [CH];

    logic [3:0]         cur_nib;
    logic               cur_ok;
    logic signed [11:0] cur_acc;
    logic [5:0]         cur_idx;
    logic [10:0]        lut_step;
    logic signed [13:0] sum;
    logic signed [11:0] new_acc;
    logic signed [11:0] idle_acc;
    logic signed [7:0]  delta;
    logic signed [7:0]  idx_sum;
    logic [5:0]         new_idx;
    logic               store_en;

    // MSM5205 step size for a given step index
    function automatic logic [10:0] step_of(input logic [5:0] i);
        case (i)
            6'd0:  step_of = 11'd16;   6'd1:  step_of = 11'd17;   6'd2:  step_of = 11'd19;
            6'd3:  step_of = 11'd21;   6'd4:  step_of = 11'd23;   6'd5:  step_of = 11'd25;
            6'd6:  step_of = 11'd28;   6'd7:  step_of = 11'd31;   6'd8:  step_of = 11'd34;
            6'd9:  step_of = 11'd37;   6'd10: step_of = 11'd41;   6'd11: step_of = 11'd45;
            6'd12: step_of = 11'd50;   6'd13: step_of = 11'd55;   6'd14: step_of = 11'd60;
            6'd15: step_of = 11'd66;   6'd16: step_of = 11'd73;   6'd17: step_of = 11'd80;
            6'd18: step_of = 11'd88;   6'd19: step_of = 11'd97;   6'd20: step_of = 11'd107;
            6'd21: step_of = 11'd118;  6'd22: step_of = 11'd130;  6'd23: step_of = 11'd143;
            6'd24: step_of = 11'd157;  6'd25: step_of = 11'd173;  6'd26: step_of = 11'd190;
            6'd27: step_of = 11'd209;  6'd28: step_of = 11'd230;  6'd29: step_of = 11'd253;
            6'd30: step_of = 11'd279;  6'd31: step_of = 11'd307;  6'd32: step_of = 11'd337;
            6'd33: step_of = 11'd371;  6'd34: step_of = 11'd408;  6'd35: step_of = 11'd449;
            6'd36: step_of = 11'd494;  6'd37: step_of = 11'd544;  6'd38: step_of = 11'd598;
            6'd39: step_of = 11'd658;  6'd40: step_of = 11'd724;  6'd41: step_of = 11'd796;
            6'd42: step_of = 11'd876;  6'd43: step_of = 11'd963;  6'd44: step_of = 11'd1060;
            6'd45: step_of = 11'd1166; 6'd46: step_of = 11'd1282; 6'd47: step_of = 11'd1411;
            default: step_of = 11'd1552;
        endcase
    endfunction

    // Select the per-channel state of the channel currently being processed
    always_comb begin
        cur_nib = '0;
        cur_ok  = 1'b0;
        cur_acc = '0;
        cur_idx = '0;
        for (int n = 0; n < CH; n++) begin
            if (ch == 3'(n)) begin
                cur_nib = hold_nib[n];
                cur_ok  = hold_ok[n];
                cur_acc = acc[n];
                cur_idx = idx[n];
            end
        end
    end

    // Saturating accumulator update, step index adaptation and idle-channel behaviour
    always_comb begin
        lut_step = step_of(cur_idx);
        if (cur_nib[3])
            sum = {{2{cur_acc[11]}}, cur_acc} - $signed({2'b00, q});
        else
            sum = {{2{cur_acc[11]}}, cur_acc} + $signed({2'b00, q});
        if (sum > 14'sd2047)
            new_acc = 12'sd2047;
        else if (sum < -14'sd2048)
            new_acc = -12'sd2048;
        else
            new_acc = sum[11:0];
        delta   = cur_nib[2] ? $signed({5'b0, cur_nib[1:0], 1'b0}) + 8'sd2 : -8'sd1;
        idx_sum = $signed({2'b00, cur_idx}) + delta;
        if (idx_sum < 8'sd0)
            new_idx = 6'd0;
        else if (idx_sum > 8'sd48)
            new_idx = 6'd48;
        else
            new_idx = idx_sum[5:0];
`ifdef JT5205_DECAY_EN
        // -1 >>> 1 would stick at -1 forever, so it is forced to zero
        idle_acc = (cur_acc == -12'sd1) ? 12'sd0 : (cur_acc >>> 1);
`else
        idle_acc = cur_acc;
`endif
    end

    // A new cen_lo wins over a pending STORE, so an aborted frame never writes back
    assign store_en = cen_hf && !cen_lo && (state == STORE);

    // Frame sequencer: walks LOAD/ADD0..2/STORE once per channel, restarting on cen_lo
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ch        <= '0;
            step      <= '0;
            q         <= '0;
            sample_ok <= 1'b0;
        end else begin
            sample_ok <= 1'b0;
            if (cen_hf) begin
                if (cen_lo) begin
                    state <= LOAD;
                    ch    <= '0;
                end else begin
                    case (state)
                        IDLE: state <= IDLE;
                        LOAD: begin
                            step  <= lut_step;
                            q     <= 12'(lut_step >> 3);
                            state <= ADD0;
                        end
                        ADD0: begin
                            if (cur_nib[2]) q <= q + 12'(step);
                            state <= ADD1;
                        end
                        ADD1: begin
                            if (cur_nib[1]) q <= q + 12'(step >> 1);
                            state <= ADD2;
                        end
                        ADD2: begin
                            if (cur_nib[0]) q <= q + 12'(step >> 2);
                            state <= STORE;
                        end
                        STORE: begin
                            if (ch == 3'(CH - 1)) begin
                                state     <= IDLE;
                                sample_ok <= 1'b1;
                            end else begin
                                ch    <= ch + 3'd1;
                                state <= LOAD;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

    // Capture all channel nibbles at the frame rate and acknowledge the valid ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_ack <= '0;
            for (int n = 0; n < CH; n++) begin
                hold_nib[n] <= '0;
                hold_ok[n]  <= 1'b0;
            end
        end else begin
            din_ack <= cen_lo ? din_ok : '0;
            if (cen_lo) begin
                for (int n = 0; n < CH; n++) begin
                    hold_nib[n] <= din[4*n +: 4];
                    hold_ok[n]  <= din_ok[n];
                end
            end
        end
    end

    // Write back accumulator and step index of the channel finishing STORE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < CH; n++) begin
                acc[n] <= '0;
                idx[n] <= '0;
            end
        end else if (store_en) begin
            for (int n = 0; n < CH; n++) begin
                if (ch == 3'(n)) begin
                    if (cur_ok) begin
                        acc[n] <= new_acc;
                        idx[n] <= new_idx;
                    end else begin
                        acc[n] <= idle_acc;
                    end
                end
            end
        end
    end

    // Output samples are the 12-bit accumulators scaled up to SW bits
    for (genvar n = 0; n < CH; n++) begin : g_sound
        assign sound[SW*n +: SW] = SW'(acc[n]) << (SW - 12);
    end

endmodule
